// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Row-scanning front end for a 4x4 keypad, feeding key_decode.
//   Rows are driven one-hot, active-high. Each row is held for SCAN_DIV
//   cycles. The raw active-low columns are synchronised, then debounced
//   on both press and release. Only single-key closures are accepted.
//   An accepted key is presented as a one-hot row plus an active-low
//   column, with a one-cycle key_valid pulse.
//
//   Optional build macro: KEYPAD_REPEAT_EN
//     When defined, holding a key emits extra key_valid pulses. The first
//     comes REPEAT_DELAY cycles after acceptance, then one every
//     REPEAT_PERIOD cycles.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   col_n[3:0] in   raw columns, pulled up; bit 3 = column 1; 0 = closed
//   row[3:0]   out  one-hot row drive; 4'b1000 = row 1
//   key_row    out  one-hot row of the last accepted key
//   key_col    out  active-low column of the last accepted key
//   key_valid  out  one-cycle pulse when a key is accepted (or repeats)
//   key_held   out  high while the accepted key is still closed
module keypad_scanner #(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 20,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col_n,
    output logic [3:0] row,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW_W = $clog2(SCAN_DIV);
    localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_DONE    = DB_W'(DEBOUNCE_CNT);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_PERIOD < 1 ||
        REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_params
        $error("keypad_scanner: invalid parameter set");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, col_s_q;
    logic [3:0]      row_q, row_d;
    logic [3:0]      cand_row_q, cand_row_d;
    logic [3:0]      cand_col_q, cand_col_d;
    logic [3:0]      key_row_q, key_row_d;
    logic [3:0]      key_col_q, key_col_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [DB_W-1:0] dbc_q, dbc_d, dbc_inc;
    logic            one_low, all_high, cand_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
    // Reloading to DELAY-PERIOD makes every later fire land PERIOD cycles apart.
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    function automatic logic [3:0] rot_right(input logic [3:0] r);
        return {r[0], r[3:1]};
    endfunction

    always_comb begin
        dbc_inc  = (dbc_q == DB_DONE) ? dbc_q : dbc_q + 1'b1;
        one_low  = $onehot(~col_s_q);
        all_high = (col_s_q == 4'b1111);
        // The candidate's single zero column is still closed.
        cand_low = |(~col_s_q & ~cand_col_q);

        state_d     = state_q;
        row_d       = row_q;
        dwell_d     = dwell_q;
        dbc_d       = dbc_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        key_row_d   = key_row_q;
        key_col_d   = key_col_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = '0;
`endif

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (one_low) begin
                        cand_col_d = col_s_q;
                        cand_row_d = row_q;
                        dbc_d      = '0;
                        state_d    = DEBOUNCE;
                    end else begin
                        row_d = rot_right(row_q);
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_s_q == cand_col_q) begin
                    dbc_d = dbc_inc;
                    if (dbc_inc == DB_DONE) begin
                        key_row_d   = cand_row_q;
                        key_col_d   = cand_col_q;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = HELD;
                    end
                end else begin
                    row_d   = rot_right(cand_row_q);
                    dwell_d = '0;
                    state_d = SCAN;
                end
            end
            HELD: begin
                if (all_high) begin
                    dbc_d   = '0;
                    state_d = RELEASE;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (rpt_q + 1'b1 == RPT_FIRE) begin
                        key_valid_d = 1'b1;
                        rpt_d       = RPT_RELOAD;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
`endif
                end
            end
            RELEASE: begin
                if (all_high) begin
                    dbc_d = dbc_inc;
                    if (dbc_inc == DB_DONE) begin
                        key_held_d = 1'b0;
                        row_d      = rot_right(cand_row_q);
                        dwell_d    = '0;
                        state_d    = SCAN;
                    end
                end else if (cand_low) begin
                    state_d = HELD;
                end else begin
                    // Another column closed while ours is open: not a stable release.
                    dbc_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SCAN;
            sync1_q     <= 4'b1111;
            col_s_q     <= 4'b1111;
            row_q       <= 4'b1000;
            dwell_q     <= '0;
            dbc_q       <= '0;
            cand_row_q  <= 4'b1000;
            cand_col_q  <= 4'b1111;
            key_row_q   <= 4'b0000;
            key_col_q   <= 4'b1111;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= col_n;
            col_s_q     <= sync1_q;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            dbc_q       <= dbc_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= rpt_d;
`endif
        end
    end

    assign row       = row_q;
    assign key_row   = key_row_q;
    assign key_col   = key_col_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    localparam int SCAN_DIV      = 8;
    localparam int DEBOUNCE_CNT  = 4;
    localparam int REPEAT_DELAY  = 20;
    localparam int REPEAT_PERIOD = 10;

    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_HELD = 2;
    localparam int M_REL  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] col_n;
    logic [3:0] row, key_row, key_col;
    logic       key_valid, key_held;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .col_n    (col_n),
        .row      (row),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int pulses = 0;

    // Physical keypad: bit r*4+c set = key at row r, column c (0-based) closed.
    logic [15:0] press_mask;

    // Reference model state.
    logic [3:0] m_s1, m_s2, m_ccol, m_kr, m_kc;
    logic       m_kv, m_kh;
    int         m_ridx, m_dwell, m_cnt, m_mode;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] keypad_cols(input logic [3:0] drv, input logic [15:0] mask);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (drv[3-r] && mask[r*4+k]) c[3-k] = 1'b0;
        return c;
    endfunction

    // key_decode value: (row-1)*4 + (col-1), or -1 when nothing is present.
    function automatic int decode(input logic [3:0] kr, input logic [3:0] kc);
        int r, c;
        r = -1;
        c = -1;
        for (int i = 0; i < 4; i++) begin
            if (kr[3-i])  r = i;
            if (!kc[3-i]) c = i;
        end
        if (r < 0 || c < 0) return -1;
        return r * 4 + c;
    endfunction

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_ccol = 4'hF;
        m_kr = 4'h0; m_kc = 4'hF; m_kv = 1'b0; m_kh = 1'b0;
        m_ridx = 0; m_dwell = 0; m_cnt = 0; m_mode = M_SCAN;
    endtask

    // One clock of the behavioural keypad scanner; cin is the raw column value at the edge.
    task automatic model_step(input logic [3:0] cin);
        logic [3:0] cs;
        cs   = m_s2;
        m_kv = 1'b0;
        case (m_mode)
            M_SCAN: begin
                if (m_dwell == SCAN_DIV - 1) begin
                    m_dwell = 0;
                    if ($countones(~cs) == 1) begin
                        m_ccol = cs;
                        m_cnt  = 0;
                        m_mode = M_DEB;
                    end else begin
                        m_ridx = (m_ridx + 1) % 4;
                    end
                end else begin
                    m_dwell++;
                end
            end
            M_DEB: begin
                if (cs == m_ccol) begin
                    m_cnt++;
                    if (m_cnt == DEBOUNCE_CNT) begin
                        m_kr   = 4'b1000 >> m_ridx;
                        m_kc   = m_ccol;
                        m_kv   = 1'b1;
                        m_kh   = 1'b1;
                        m_mode = M_HELD;
                    end
                end else begin
                    m_mode  = M_SCAN;
                    m_ridx  = (m_ridx + 1) % 4;
                    m_dwell = 0;
                end
            end
            M_HELD: begin
                if (cs == 4'hF) begin
                    m_mode = M_REL;
                    m_cnt  = 0;
                end
            end
            default: begin
                if (cs == 4'hF) begin
                    m_cnt++;
                    if (m_cnt == DEBOUNCE_CNT) begin
                        m_kh    = 1'b0;
                        m_mode  = M_SCAN;
                        m_ridx  = (m_ridx + 1) % 4;
                        m_dwell = 0;
                    end
                end else if ((cs | m_ccol) != 4'hF) begin
                    m_mode = M_HELD;
                end else begin
                    m_cnt = 0;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = cin;
    endtask

    task automatic compare_all();
        logic [3:0] er;
        er = 4'b1000 >> m_ridx;
        check_eq("row", row, er);
        check_eq("key_row", key_row, m_kr);
        check_eq("key_col", key_col, m_kc);
        check_eq("key_valid", key_valid, m_kv);
        check_eq("key_held", key_held, m_kh);
        if (key_valid === 1'b1) pulses++;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step(col_n);
        #1;
        col_n = keypad_cols(row, press_mask);
        @(negedge clk);
        compare_all();
    endtask

    task automatic scen_press(input int tr, input int tc, input bit bouncy);
        logic [15:0] bitm;
        bitm   = 16'h1 << (tr * 4 + tc);
        pulses = 0;
        if (bouncy)
            for (int i = 0; i < 12; i++) begin
                press_mask = ((i / 2) % 2 == 0) ? bitm : 16'h0;
                cycle();
            end
        press_mask = bitm;
        for (int i = 0; i < 200 && !m_kh; i++) cycle();
        cycle();
        check_eq("press_held", key_held, 1);
        check_eq("press_decode", decode(key_row, key_col), tr * 4 + tc);
        repeat ($urandom_range(0, 30)) cycle();
        if (bouncy)
            for (int i = 0; i < 10; i++) begin
                press_mask = (i % 2 == 0) ? 16'h0 : bitm;
                cycle();
            end
        press_mask = 16'h0;
        for (int i = 0; i < 100 && m_kh; i++) cycle();
        repeat (3) cycle();
        check_eq("press_pulses", pulses, 1);
        check_eq("release_held", key_held, 0);
    endtask

    task automatic scen_multi(input int tr, input int c1, input int c2);
        pulses     = 0;
        press_mask = (16'h1 << (tr * 4 + c1)) | (16'h1 << (tr * 4 + c2));
        repeat (80) cycle();
        press_mask = 16'h0;
        repeat (10) cycle();
        check_eq("multi_pulses", pulses, 0);
        check_eq("multi_held", key_held, 0);
    endtask

    task automatic scen_reset_deb(input int tr, input int tc);
        pulses     = 0;
        press_mask = 16'h1 << (tr * 4 + tc);
        for (int i = 0; i < 200 && m_mode != M_DEB; i++) cycle();
        repeat (2) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_row", row, 4'b1000);
        check_eq("rst_mid_key_row", key_row, 4'b0000);
        check_eq("rst_mid_key_col", key_col, 4'b1111);
        check_eq("rst_mid_key_valid", key_valid, 0);
        check_eq("rst_mid_key_held", key_held, 0);
        press_mask = 16'h0;
        model_reset();
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (6) cycle();
        check_eq("rst_mid_pulses", pulses, 0);
    endtask

    initial begin
        int sel, tr, c1, c2;
        reset_n    = 1'b0;
        col_n      = 4'hF;
        press_mask = 16'h0;
        model_reset();
        repeat (2) cycle();
        check_eq("rst_row", row, 4'b1000);
        check_eq("rst_key_col", key_col, 4'b1111);
        check_eq("rst_key_held", key_held, 0);
        reset_n = 1'b1;

        // Idle rotation with no keys down.
        pulses = 0;
        repeat (40) cycle();
        check_eq("idle_pulses", pulses, 0);
        check_eq("idle_key_col", key_col, 4'hF);

        scen_press(1, 2, 1'b0);   // row 2 / column 3, decodes to 6
        scen_press(2, 3, 1'b1);   // bouncy press/release on column 4 (col 1110)
        scen_multi(3, 1, 2);      // col 1001 on row 0001
        scen_reset_deb(0, 0);

        for (int it = 0; it < 16; it++) begin
            sel = $urandom_range(0, 4);
            tr  = $urandom_range(0, 3);
            c1  = $urandom_range(0, 3);
            c2  = (c1 + $urandom_range(1, 3)) % 4;
            case (sel)
                0: begin
                    pulses = 0;
                    repeat ($urandom_range(10, 40)) cycle();
                    check_eq("idle_rand_pulses", pulses, 0);
                end
                1: scen_press(tr, c1, 1'b0);
                2: scen_press(tr, c1, 1'b1);
                3: scen_multi(tr, c1, c2);
                default: scen_reset_deb(tr, c1);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
